pipeline_ctrl: RTL

//  Sequencing controller for the 3-stage RV32I pipeline (F | X | W).
//  - Owns the W-stage instruction register and the X/W valid bits.
//  - Drives PC enable/redirect, operand forwarding selects, and branch flush/bubbling.
//  - Freezes the pipe on data-memory stall.
//  - Sits beside the combinational decoder. Datapath gates every side effect
//    (regfile, dmem, CSR writes) with x_valid/w_valid.

---
 rtl/pipeline_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencing controller for a 3-stage (F | X | W) RV32I pipe.
// Owns the W instruction register and the X/W valid bits. Drives PC enable
// and redirect, operand forwarding selects, and branch flush. Freezes the
// whole pipe while data memory stalls.
// Optional feature macro: HAZARD_FWD_EN (forward W results into X; no RAW stall).
module pipeline_ctrl #(
    parameter int unsigned BOOT_BUBBLES = 1,  // 1..7
    parameter int unsigned FLUSH_CYCLES = 1   // 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x_inst,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        dmem_stall,
    output logic        pc_wen,
    output logic        pc_sel,
    output logic        x_wen,
    output logic        x_valid,
    output logic [31:0] w_inst,
    output logic        w_valid,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] BOOT_INIT  = 3'(BOOT_BUBBLES - 1);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_w_inst;
    logic        r_w_valid;

    state_t      w_state_nxt;
    logic [2:0]  w_cnt_nxt;
    logic [31:0] w_w_inst_nxt;
    logic        w_w_valid_nxt;

    // Instruction fields of X and W.
    logic [6:0] w_x_op;
    logic [6:0] w_w_op;
    logic [4:0] w_x_rs1;
    logic [4:0] w_x_rs2;
    logic [2:0] w_x_funct3;
    logic [4:0] w_w_rd;

    assign w_x_op     = x_inst[6:0];
    assign w_x_rs1    = x_inst[19:15];
    assign w_x_rs2    = x_inst[24:20];
    assign w_x_funct3 = x_inst[14:12];
    assign w_w_op     = r_w_inst[6:0];
    assign w_w_rd     = r_w_inst[11:7];

    logic w_x_valid;
    logic w_w_writes_rd;
    logic w_w_is_load;
    logic w_x_reads_rs1;
    logic w_x_reads_rs2;
    logic w_br_cond;
    logic w_x_taken;
    logic w_raw_a;
    logic w_raw_b;
    logic w_raw_stall;
    logic w_redirect;

    // X only holds a real instruction in RUN; reset overrides everything.
    assign w_x_valid = (r_state == ST_RUN) && !rst;

    // Decode the register-usage and control-flow class of X and W.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        w_w_writes_rd = 1'b0;
        w_x_reads_rs1 = 1'b0;
        w_x_reads_rs2 = 1'b0;
        w_br_cond     = 1'b0;

        unique case (w_w_op)
            OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
                w_w_writes_rd = r_w_valid && (w_w_rd != 5'd0);
            default: w_w_writes_rd = 1'b0;
        endcase

        unique case (w_x_op)
            OP_R, OP_STORE, OP_BRANCH: begin
                w_x_reads_rs1 = 1'b1;
                w_x_reads_rs2 = 1'b1;
            end
            OP_I, OP_LOAD, OP_JALR: w_x_reads_rs1 = 1'b1;
            default: ;
        endcase

        unique case (w_x_funct3)
            3'b000:  w_br_cond = br_eq;    // BEQ
            3'b001:  w_br_cond = !br_eq;   // BNE
            3'b100:  w_br_cond = br_lt;    // BLT
            3'b101:  w_br_cond = !br_lt;   // BGE
            3'b110:  w_br_cond = br_lt;    // BLTU
            3'b111:  w_br_cond = !br_lt;   // BGEU
            default: w_br_cond = 1'b0;     // reserved encodings never branch
        endcase
    end

    assign w_w_is_load = (w_w_op == OP_LOAD);
    assign w_x_taken   = (w_x_op == OP_JAL) || (w_x_op == OP_JALR) ||
                         ((w_x_op == OP_BRANCH) && w_br_cond);

    assign w_raw_a = w_x_valid && w_w_writes_rd && w_x_reads_rs1 && (w_x_rs1 == w_w_rd);
    assign w_raw_b = w_x_valid && w_w_writes_rd && w_x_reads_rs2 && (w_x_rs2 == w_w_rd);

`ifdef HAZARD_FWD_EN
    assign w_raw_stall = 1'b0;
    assign fwd_a_sel   = w_raw_a ? (w_w_is_load ? 2'b10 : 2'b01) : 2'b00;
    assign fwd_b_sel   = w_raw_b ? (w_w_is_load ? 2'b10 : 2'b01) : 2'b00;
`else
    assign w_raw_stall = w_raw_a || w_raw_b;
    assign fwd_a_sel   = 2'b00;
    assign fwd_b_sel   = 2'b00;
`endif

    // A stalled X compares stale operands, so its redirect waits for the retry.
    assign w_redirect = w_x_valid && w_x_taken && !w_raw_stall;

    // Next-state, W advance and PC/X enables.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_w_inst_nxt  = r_w_inst;
        w_w_valid_nxt = r_w_valid;
        pc_wen        = 1'b0;
        x_wen         = 1'b0;
        pc_sel        = 1'b0;

        unique case (r_state)
            ST_BOOT, ST_FLUSH: begin
                pc_wen        = 1'b1;
                x_wen         = 1'b1;
                w_w_inst_nxt  = x_inst;
                w_w_valid_nxt = 1'b0;
                if (r_cnt == 3'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            ST_RUN: begin
                pc_sel = w_redirect;
                if (w_raw_stall) begin
                    w_w_inst_nxt  = NOP;
                    w_w_valid_nxt = 1'b0;
                end else begin
                    pc_wen        = 1'b1;
                    x_wen         = 1'b1;
                    w_w_inst_nxt  = x_inst;
                    w_w_valid_nxt = 1'b1;
                    if (w_redirect) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = FLUSH_INIT;
                    end
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase

        if (dmem_stall) begin
            pc_wen = 1'b0;
            x_wen  = 1'b0;
        end
        if (rst) begin
            pc_wen = 1'b0;
            x_wen  = 1'b0;
            pc_sel = 1'b0;
        end
    end

    // State, counter and W register; a data-memory stall holds all of them.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state   <= ST_BOOT;
            r_cnt     <= BOOT_INIT;
            r_w_inst  <= NOP;
            r_w_valid <= 1'b0;
        end else if (!dmem_stall) begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_w_inst  <= w_w_inst_nxt;
            r_w_valid <= w_w_valid_nxt;
        end
    end

    assign x_valid = w_x_valid;
    assign w_inst  = r_w_inst;
    assign w_valid = r_w_valid;

endmodule
